// File: rtl/ex_div_if.sv
`default_nettype none
// ============================================================================
// ex_div_if : ID/EX-side request and write-back/hold signals of the divider
// Revision  : 1.0
// ============================================================================
interface ex_div_if #(
  parameter int XLEN = 32
);
  logic [31:0]     inst_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            reg_wen_i;
  logic            hold_flag_o;
  logic            busy_o;
  logic            div_wen_o;
  logic [4:0]      div_rd_addr_o;
  logic [XLEN-1:0] div_result_o;

  modport master (
    output inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
    input  hold_flag_o, busy_o, div_wen_o, div_rd_addr_o, div_result_o
  );

  modport slave (
    input  inst_i, op1_i, op2_i, rd_addr_i, reg_wen_i,
    output hold_flag_o, busy_o, div_wen_o, div_rd_addr_o, div_result_o
  );
endinterface
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
// ============================================================================
// ex_div   : iterative RV32M DIV/DIVU/REM/REMU unit (restoring, XLEN steps)
// Revision : 1.0
// ============================================================================
module ex_div #(
  parameter int XLEN = 32
) (
  input  wire logic clk,
  input  wire logic rst_n,
  ex_div_if.slave   bus
);

  localparam int              CW               = $clog2(XLEN);
  localparam logic [CW-1:0]   c_last_count     = CW'(XLEN - 1);
  localparam logic [6:0]      c_opcode_op      = 7'b0110011;
  localparam logic [6:0]      c_funct7_muldiv  = 7'b0000001;
  localparam logic [XLEN-1:0] c_min_int        = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [XLEN-1:0] r_dvd;
  logic [XLEN-1:0] r_dsr;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [CW-1:0]   r_count;
  logic            r_sel_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [4:0]      r_rd;
  logic            r_wen;
  logic [XLEN-1:0] r_res_out;
  logic [4:0]      r_rd_out;

  logic            w_is_div;
  logic [2:0]      w_f3;
  logic            w_signed;
  logic            w_div_zero;
  logic            w_overflow;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_op1_abs;
  logic [XLEN-1:0] w_op2_abs;
  logic            w_hold;
  logic            w_accept;
  logic            w_last_step;

  logic [XLEN:0]   w_trial;
  logic            w_fits;
  logic [XLEN-1:0] w_rem_next;
  logic [XLEN-1:0] w_quot_next;
  logic [XLEN-1:0] w_quot_signed;
  logic [XLEN-1:0] w_rem_signed;
  logic [XLEN-1:0] w_final;
  logic            w_unused_inst;

  // ---------------------------------------------------------------------------
  // Decode and special-case detection on the ID/EX operands
  // ---------------------------------------------------------------------------
  assign w_f3          = bus.inst_i[14:12];
  assign w_is_div      = (bus.inst_i[6:0] == c_opcode_op) &&
                         (bus.inst_i[31:25] == c_funct7_muldiv) && w_f3[2];
  assign w_signed      = ~w_f3[0];
  assign w_div_zero    = (bus.op2_i == '0);
  assign w_overflow    = w_signed && (bus.op1_i == c_min_int) && (bus.op2_i == '1);
  assign w_special     = w_div_zero || w_overflow;
  assign w_special_res = w_f3[1] ? (w_div_zero ? bus.op1_i : '0)
                                 : (w_div_zero ? '1 : c_min_int);
  assign w_op1_abs     = (w_signed && bus.op1_i[XLEN-1]) ? -bus.op1_i : bus.op1_i;
  assign w_op2_abs     = (w_signed && bus.op2_i[XLEN-1]) ? -bus.op2_i : bus.op2_i;
  assign w_unused_inst = ^{bus.inst_i[24:15], bus.inst_i[11:7]};

  // ---------------------------------------------------------------------------
  // One restoring step: the remainder never exceeds the divisor, so one extra
  // bit is enough to detect the borrow of the trial subtraction.
  // ---------------------------------------------------------------------------
  assign w_trial       = {r_rem, r_dvd[XLEN-1]} - {1'b0, r_dsr};
  assign w_fits        = ~w_trial[XLEN];
  assign w_rem_next    = w_fits ? w_trial[XLEN-1:0] : {r_rem[XLEN-2:0], r_dvd[XLEN-1]};
  assign w_quot_next   = {r_quot[XLEN-2:0], w_fits};
  assign w_quot_signed = r_neg_q ? -w_quot_next : w_quot_next;
  assign w_rem_signed  = r_neg_r ? -w_rem_next : w_rem_next;
  assign w_final       = r_sel_rem ? w_rem_signed : w_quot_signed;
  assign w_last_step   = (r_count == c_last_count);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_hold       = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_is_div) begin
          w_hold       = 1'b1;
          w_accept     = 1'b1;
          w_state_next = w_special ? DONE : BUSY;
        end
      end
      BUSY: begin
        w_hold = 1'b1;
        if (w_last_step) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath. Operands are captured at accept because ID/EX turns into a NOP
  // while the pipeline is held.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_rd      <= '0;
      r_wen     <= 1'b0;
      r_res_out <= '0;
      r_rd_out  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_dvd     <= w_op1_abs;
            r_dsr     <= w_op2_abs;
            r_quot    <= '0;
            r_rem     <= '0;
            r_count   <= '0;
            r_sel_rem <= w_f3[1];
            r_neg_q   <= w_signed && (bus.op1_i[XLEN-1] ^ bus.op2_i[XLEN-1]);
            r_neg_r   <= w_signed && bus.op1_i[XLEN-1];
            r_rd      <= bus.rd_addr_i;
            r_wen     <= bus.reg_wen_i;
            if (w_special) begin
              r_res_out <= w_special_res;
              r_rd_out  <= bus.rd_addr_i;
            end
          end
        end
        BUSY: begin
          r_dvd   <= {r_dvd[XLEN-2:0], 1'b0};
          r_rem   <= w_rem_next;
          r_quot  <= w_quot_next;
          r_count <= r_count + 1'b1;
          if (w_last_step) begin
            r_res_out <= w_final;
            r_rd_out  <= r_rd;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.hold_flag_o   = w_hold;
  assign bus.busy_o        = (r_state != IDLE);
  assign bus.div_wen_o     = (r_state == DONE) && r_wen;
  assign bus.div_rd_addr_o = r_rd_out;
  assign bus.div_result_o  = r_res_out;

endmodule
`default_nettype wire
